// File: rtl/gray_code_scan_display_if.sv
// ---------------------------------------------------------------------------
// gray_code_scan_display_if
// Board-side signal bundle for the Gray code scan display.
//   data_in : switch operand (asynchronous to clk)
//   mode    : 0 = binary->Gray, 1 = Gray->binary (asynchronous switch)
//   run     : 1 = auto-count source instead of data_in (asynchronous switch)
//   result  : registered conversion result
//   an      : digit enables, active-low, one-hot-low, an[WIDTH-1] leftmost
//   seg     : segments {g,f,e,d,c,b,a}, active-low
//   dp      : decimal point, active-low
// master = switch/board side that drives the inputs, slave = display block.
// ---------------------------------------------------------------------------
interface gray_code_scan_display_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             mode;
  logic             run;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] an;
  logic [6:0]       seg;
  logic             dp;

  modport master (
    output data_in, mode, run,
    input  result, an, seg, dp
  );

  modport slave (
    input  data_in, mode, run,
    output result, an, seg, dp
  );
endinterface

// File: rtl/gray_code_scan_display.sv
// ---------------------------------------------------------------------------
// gray_code_scan_display
// Binary<->Gray converter driving a multiplexed active-low seven-segment
// display, one result bit per digit shown as '0' or '1'. An optional
// auto-count source steps through the whole code space hands-free.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of gray_code_scan_display_if (switches in, result
//           and display pins out)
// Parameters:
//   WIDTH       : code bits = number of digits (2..16)
//   REFRESH_CNT : clk cycles each digit stays lit (>= 2)
//   STEP_CNT    : clk cycles between auto-count increments (>= 1)
// ---------------------------------------------------------------------------
module gray_code_scan_display #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_CNT = 100000,
  parameter int STEP_CNT    = 50000000
) (
  input logic                     clk,
  input logic                     rst_n,
  gray_code_scan_display_if.slave bus
);

  localparam int STEP_W = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam int REF_W  = $clog2(REFRESH_CNT);
  localparam int IDX_W  = $clog2(WIDTH);

  localparam logic [6:0] SEG_ONE  = 7'b1111001;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [WIDTH-1:0] DIGIT_ONE = WIDTH'(1);

  // -------------------------------------------------------------------------
  // Two-flop synchronisers; only the *_s copies are used below.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q1, data_s;
  logic             mode_q1, mode_s;
  logic             run_q1, run_s;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the
  // two-stage synchroniser into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q1 <= '0;
      data_s  <= '0;
      mode_q1 <= 1'b0;
      mode_s  <= 1'b0;
      run_q1  <= 1'b0;
      run_s   <= 1'b0;
    end else begin
      data_q1 <= bus.data_in;
      data_s  <= data_q1;
      mode_q1 <= bus.mode;
      mode_s  <= mode_q1;
      run_q1  <= bus.run;
      run_s   <= run_q1;
    end
  end

  // -------------------------------------------------------------------------
  // Auto counter: the step timer only runs while run_s is high, so dropping
  // run freezes cnt and restarts the step interval on resume.
  // -------------------------------------------------------------------------
  logic [STEP_W-1:0] step_cnt;
  logic              step_tick;
  logic [WIDTH-1:0]  cnt;

  assign step_tick = (step_cnt == STEP_W'(STEP_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      cnt      <= '0;
    end else if (!run_s) begin
      step_cnt <= '0;
    end else if (step_tick) begin
      step_cnt <= '0;
      cnt      <= cnt + WIDTH'(1);
    end else begin
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Conversion. Gray->binary is a running XOR from the MSB downwards.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] conv;
  logic             acc;

  // NOTE: every variable written in always_comb is given a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    src  = run_s ? cnt : data_s;
    conv = '0;
    acc  = 1'b0;
    if (!mode_s) begin
      conv = src ^ (src >> 1);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        acc     = acc ^ src[i];
        conv[i] = acc;
      end
    end
  end

  logic [WIDTH-1:0] result_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_r <= '0;
    else        result_r <= conv;
  end

  // -------------------------------------------------------------------------
  // Scan timer: idx = 0 is the leftmost digit, so the MSB is shown first.
  // -------------------------------------------------------------------------
  logic [REF_W-1:0] ref_cnt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == REF_W'(REFRESH_CNT - 1)) begin
      ref_cnt <= '0;
      idx     <= (idx == IDX_W'(WIDTH - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Display registers. They read the registered result every cycle, so a
  // result change shows on the lit digit one cycle later, mid-slot.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] sel;
  logic [WIDTH-1:0] an_next, an_r;
  logic [6:0]       seg_next, seg_r;
  logic             dp_next, dp_r;

  always_comb begin
    sel      = IDX_W'(WIDTH - 1) - idx;
    an_next  = ~(DIGIT_ONE << sel);
    seg_next = result_r[sel] ? SEG_ONE : SEG_ZERO;
    dp_next  = !(run_s && (idx == IDX_W'(WIDTH - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= '1;
      seg_r <= 7'b1111111;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next;
      seg_r <= seg_next;
      dp_r  <= dp_next;
    end
  end

  assign bus.result = result_r;
  assign bus.an     = an_r;
  assign bus.seg    = seg_r;
  assign bus.dp     = dp_r;

endmodule

// File: tb/tb_gray_code_scan_display.sv
// ---------------------------------------------------------------------------
// tb_gray_code_scan_display
// Self-checking bench: a 4-bit instance (REFRESH_CNT=4, STEP_CNT=8) carries
// the main scenarios, an 8-bit instance covers the wide Gray->binary case.
// Expected results are pushed to a queue when stimulus is driven and popped
// when the DUT output is due.
// ---------------------------------------------------------------------------
module tb_gray_code_scan_display;

  localparam int W  = 4;
  localparam int W8 = 8;
  localparam int RC = 4;
  localparam int SC = 8;

  localparam logic [6:0] SEG_ONE  = 7'h79;
  localparam logic [6:0] SEG_ZERO = 7'h40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  gray_code_scan_display_if #(.WIDTH(W))  bus4 ();
  gray_code_scan_display_if #(.WIDTH(W8)) bus8 ();

  gray_code_scan_display #(.WIDTH(W), .REFRESH_CNT(RC), .STEP_CNT(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  gray_code_scan_display #(.WIDTH(W8), .REFRESH_CNT(RC), .STEP_CNT(SC)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  int tests_run = 0;
  int failed    = 0;

  logic [7:0] exp_q[$];

  // Reference model
  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int k = 1; k < 8; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic int low_pos(input logic [3:0] a);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) p = i;
    return p;
  endfunction

  // Runs n auto-count steps starting at model count c0. Entry point: the
  // negedge following the edge on which run_s became 1 (or the negedge after
  // the previous step's post-check). dp is checked every cycle.
  logic saw_dp_low;

  task automatic run_steps(input int n, input int c0);
    int c;
    logic [7:0] e;
    c = c0;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < ((s == 0) ? SC : SC - 1); k++) begin
        @(negedge clk);
        tests_run++;
        if (bus4.dp !== ((bus4.an == 4'b1110) ? 1'b0 : 1'b1)) begin
          failed++;
          $display("FAIL dp_slot: an=%b dp=%b", bus4.an, bus4.dp);
        end
        if (bus4.dp === 1'b0) saw_dp_low = 1'b1;
      end
      // Pulse edge just happened: result still shows the previous count.
      exp_q.push_back(bin2gray(8'(c)));
      e = exp_q.pop_front();
      tests_run++;
      if (bus4.result !== e[3:0]) begin
        failed++;
        $display("FAIL step_pre cnt=%0d: got %b want %b", c, bus4.result, e[3:0]);
      end
      c = (c + 1) % 16;
      exp_q.push_back(bin2gray(8'(c)));
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (bus4.result !== e[3:0]) begin
        failed++;
        $display("FAIL step_post cnt=%0d: got %b want %b", c, bus4.result, e[3:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus4.data_in = 4'($urandom);
    bus4.mode    = 1'($urandom);
    bus4.run     = 1'($urandom);
    bus8.data_in = 8'($urandom);
    bus8.mode    = 1'($urandom);
    bus8.run     = 1'($urandom);
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus4.result !== 4'h0 || bus4.an !== 4'hF || bus4.seg !== 7'h7F || bus4.dp !== 1'b1) begin
      failed++;
      $display("FAIL reset4: result=%h an=%h seg=%h dp=%b want 0 F 7F 1",
               bus4.result, bus4.an, bus4.seg, bus4.dp);
    end
    tests_run++;
    if (bus8.result !== 8'h00 || bus8.an !== 8'hFF || bus8.seg !== 7'h7F || bus8.dp !== 1'b1) begin
      failed++;
      $display("FAIL reset8: result=%h an=%h seg=%h dp=%b want 00 FF 7F 1",
               bus8.result, bus8.an, bus8.seg, bus8.dp);
    end
    bus4.data_in = '0; bus4.mode = 1'b0; bus4.run = 1'b0;
    bus8.data_in = '0; bus8.mode = 1'b0; bus8.run = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus4.an !== 4'b0111 || bus4.seg !== SEG_ZERO) begin
      failed++;
      $display("FAIL first_digit4: an=%b seg=%h want 0111 40", bus4.an, bus4.seg);
    end
    tests_run++;
    if (bus8.an !== 8'b0111_1111) begin
      failed++;
      $display("FAIL first_digit8: an=%b want 01111111", bus8.an);
    end
  endtask

  task automatic test_bin_to_gray();
    logic [7:0] e;
    logic [3:0] prev_an, exp_an;
    logic [6:0] exp_seg;
    bit         found;
    @(negedge clk);
    bus4.data_in = 4'b1011;
    bus4.mode    = 1'b0;
    exp_q.push_back(bin2gray(8'b0000_1011));
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus4.result !== 4'b0000) begin
      failed++;
      $display("FAIL b2g_latency_early: got %b want 0000", bus4.result);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (bus4.result !== e[3:0]) begin
      failed++;
      $display("FAIL b2g_result: got %b want %b", bus4.result, e[3:0]);
    end
    // Align to the start of the leftmost-digit slot, then follow one scan.
    found   = 1'b0;
    prev_an = bus4.an;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (bus4.an == 4'b0111 && prev_an != 4'b0111) found = 1'b1;
      prev_an = bus4.an;
    end
    tests_run++;
    if (!found) begin
      failed++;
      $display("FAIL scan_align: an=%b never entered 0111 within 40 cycles", bus4.an);
    end
    for (int j = 0; j < 16; j++) begin
      if (j != 0) @(negedge clk);
      exp_an  = 4'b1111 ^ (4'b1000 >> (j / 4));
      exp_seg = e[3 - j / 4] ? SEG_ONE : SEG_ZERO;
      tests_run++;
      if (bus4.an !== exp_an || bus4.seg !== exp_seg || bus4.dp !== 1'b1) begin
        failed++;
        $display("FAIL scan cyc%0d: an=%b seg=%h dp=%b want %b %h 1",
                 j, bus4.an, bus4.seg, bus4.dp, exp_an, exp_seg);
      end
      tests_run++;
      if ($countones(~bus4.an) != 1) begin
        failed++;
        $display("FAIL an_onehot: an=%b", bus4.an);
      end
    end
  endtask

  task automatic test_gray_to_bin();
    logic [7:0] e4, e8;
    logic [6:0] exp_seg;
    @(negedge clk);
    bus4.data_in = 4'b1110;
    bus4.mode    = 1'b1;
    bus8.data_in = 8'hFF;
    bus8.mode    = 1'b1;
    exp_q.push_back(gray2bin(8'b0000_1110));
    exp_q.push_back(gray2bin(8'hFF));
    repeat (3) @(negedge clk);
    e4 = exp_q.pop_front();
    e8 = exp_q.pop_front();
    tests_run++;
    if (bus4.result !== e4[3:0]) begin
      failed++;
      $display("FAIL g2b_result4: got %b want %b", bus4.result, e4[3:0]);
    end
    tests_run++;
    if (bus8.result !== e8) begin
      failed++;
      $display("FAIL g2b_result8: got %h want %h", bus8.result, e8);
    end
    // The lit digit must follow the new result from the very next cycle.
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      exp_seg = e4[low_pos(bus4.an)] ? SEG_ONE : SEG_ZERO;
      tests_run++;
      if (bus4.seg !== exp_seg) begin
        failed++;
        $display("FAIL seg_follow cyc%0d: an=%b seg=%h want %h", j, bus4.an, bus4.seg, exp_seg);
      end
    end
  endtask

  task automatic test_auto_count();
    @(negedge clk);
    bus4.mode = 1'b0;
    bus4.run  = 1'b1;
    saw_dp_low = 1'b0;
    repeat (2) @(negedge clk);
    // 21 steps: a full wrap through 15->0, ending at cnt = 5.
    run_steps(21, 0);
    tests_run++;
    if (!saw_dp_low) begin
      failed++;
      $display("FAIL dp_seen: got dp never low want low on an=1110");
    end
  endtask

  task automatic test_hold_resume();
    logic [7:0] e;
    bus4.run     = 1'b0;
    bus4.data_in = 4'b1001;
    exp_q.push_back(bin2gray(8'b0000_1001));
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (bus4.result !== e[3:0]) begin
      failed++;
      $display("FAIL hold_result: got %b want %b", bus4.result, e[3:0]);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (bus4.result !== e[3:0] || bus4.dp !== 1'b1) begin
      failed++;
      $display("FAIL hold_stable: result=%b dp=%b want %b 1", bus4.result, bus4.dp, e[3:0]);
    end
    bus4.run = 1'b1;
    repeat (2) @(negedge clk);
    run_steps(1, 5);
    // Mode toggle while running changes only the conversion.
    bus4.mode = 1'b1;
    exp_q.push_back(gray2bin(8'd6));
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (bus4.result !== e[3:0]) begin
      failed++;
      $display("FAIL mode_toggle_run: got %b want %b", bus4.result, e[3:0]);
    end
    bus4.mode = 1'b0;
    exp_q.push_back(bin2gray(8'd6));
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (bus4.result !== e[3:0]) begin
      failed++;
      $display("FAIL mode_back_run: got %b want %b", bus4.result, e[3:0]);
    end
  endtask

  task automatic test_async_reset();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus4.result !== 4'h0 || bus4.an !== 4'hF || bus4.seg !== 7'h7F || bus4.dp !== 1'b1) begin
      failed++;
      $display("FAIL async_reset: result=%h an=%h seg=%h dp=%b want 0 F 7F 1",
               bus4.result, bus4.an, bus4.seg, bus4.dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus4.an !== 4'b0111) begin
      failed++;
      $display("FAIL async_release_an: got %b want 0111", bus4.an);
    end
    @(negedge clk);
    run_steps(2, 0);
  endtask

  initial begin
    bus4.data_in = '0; bus4.mode = 1'b0; bus4.run = 1'b0;
    bus8.data_in = '0; bus8.mode = 1'b0; bus8.run = 1'b0;
    test_reset();
    test_bin_to_gray();
    test_gray_to_bin();
    test_auto_count();
    test_hold_resume();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gray_code_scan_display.md
Name: gray_code_scan_display

Overview:
Parametrised binary/Gray code converter that drives a multiplexed, active-low seven-segment display. Each display digit shows one result bit as '0' or '1'. Conversion direction is selectable at run time. An auto-count mode steps an internal binary counter so that the whole Gray sequence is shown hands-free. The block is a board-top display block, fed directly by slide switches and driving AN/segment pins.

Parameters:
WIDTH, 4, number of code bits; equals number of display digits; legal range 2..16
REFRESH_CNT, 100000, clk cycles each digit stays lit; legal range >= 2
STEP_CNT, 50000000, clk cycles between auto-count increments; legal range >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  WIDTH  switch operand, asynchronous to clk
mode  input  1  0 = binary->Gray, 1 = Gray->binary; asynchronous switch
run  input  1  1 = use the auto-count source instead of data_in; asynchronous switch
result  output  WIDTH  registered conversion result
an  output  WIDTH  digit enables, active-low, one-hot-low; an[WIDTH-1] is the leftmost digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Every flop clears immediately when rst_n = 0, including mid-scan or mid-count.
- Reset values: result = 0, an = all ones (all digits blank), seg = 7'b1111111, dp = 1. All internal counters are 0.
- Input synchronisation: data_in, mode and run each pass through a 2-flop synchroniser. These synchronised copies are the only copies used internally.
- Source select: src = data_s when run_s = 0, otherwise src = cnt.
- Auto counter cnt (WIDTH bits):
  - A step timer counts 0..STEP_CNT-1 and pulses on its terminal count.
  - While run_s = 1, each pulse does cnt <= cnt + 1, wrapping from 2^WIDTH-1 to 0.
  - While run_s = 0, the step timer is held at 0 and cnt holds its value, so resuming continues from that value.
- Conversion rules:
  - mode_s = 0: out = src ^ (src >> 1).
  - mode_s = 1: out[i] = XOR of src[WIDTH-1:i], for every i.
- Result register: result <= out every cycle.
  - Latency from a data_in or mode change to result is 3 rising edges (2 sync + 1 register).
  - Latency from a cnt change to result is 1 edge.
- Scan timer:
  - A refresh counter counts 0..REFRESH_CNT-1.
  - At the terminal count it wraps to 0, and digit index idx advances; idx wraps from WIDTH-1 to 0.
  - idx = k selects physical digit WIDTH-1-k, so the scan runs left to right and the MSB is shown first.
- Display registers, updated every cycle from idx and result:
  - an = all ones except bit (WIDTH-1-idx), which is 0.
  - seg = 7'b1111001 ('1') if result[WIDTH-1-idx] = 1, else 7'b1000000 ('0').
  - dp = 0 only when run_s = 1 and idx = WIDTH-1 (rightmost digit); otherwise dp = 1.
  - Display registers lag result by 1 cycle.
  - First valid digit output appears on the first edge after reset release: an = ~(1 << (WIDTH-1)).
- Boundary conditions:
  - A mode toggle while run_s = 1 changes only the conversion; cnt is untouched.
  - A result change mid-digit takes effect on seg in the next cycle, without waiting for the next scan slot.
  - A run toggle coinciding with a step pulse: the synchronised run_s value in that cycle decides whether cnt increments.
  - an never has more than one bit low.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> result = 0, an = 4'hF, seg = 7'h7F, dp = 1. Deassert -> one edge later an = 4'b0111.
- Bin->Gray, WIDTH = 4, REFRESH_CNT = 4: data_in = 4'b1011, mode = 0 -> result = 4'b1110 after 3 edges. an cycles 0111/1011/1101/1110 at 4 cycles each, with seg = 79,79,79,40 (hex).
- Gray->bin: data_in = 4'b1110, mode = 1 -> result = 4'b1011. With WIDTH = 8, data_in = 8'hFF -> result = 8'hAA.
- Auto-count, STEP_CNT = 8, mode = 0, run = 1 -> result steps 0,1,3,2,6,7,5,4,12,...,8 (8 cycles per step), then wraps to 0. dp = 0 only on the an = 4'b1110 slot.
- Hold/resume: drop run at cnt = 5 -> result returns to conv(data_in) and cnt stays 5. Raise run again -> the next step shows conv(6).
- Async reset mid-scan, mid-count: pull rst_n low without a clock edge -> outputs return to reset values immediately. After release, cnt restarts from 0.
